// File: rtl/riscv_pkg.sv
// Shared RV64I definitions: immediate format codes (common with the decoder
// side), packer FSM states, and a signed-range helper.
package riscv_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } pack_state_t;

  // True when v[63:n-1] are all equal, i.e. v fits in an n-bit signed field.
  function automatic logic fits_signed(input logic [63:0] v, input int unsigned n);
    logic [63:0] s;
    s = $unsigned($signed(v) >>> (n - 1));
    return (s == 64'd0) || (s == {64{1'b1}});
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational immediate scatter: clears the format's immediate field in the
// template, ORs in the immediate bits, and reports whether the immediate is
// representable in that format.
module imm_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  imm_src,
  input  logic [31:0] template_word,
  input  logic [63:0] imm,
  output logic [31:0] packed_word,
  output logic        legal
);

  // Per-format bit placement and range check; unknown codes pass the template through.
  always_comb begin
    packed_word = template_word;
    legal       = 1'b0;
    case (imm_src)
      IMM_I: begin
        packed_word = {imm[11:0], template_word[19:0]};
        legal       = fits_signed(imm, 12);
      end
      IMM_S: begin
        packed_word = {imm[11:5], template_word[24:12], imm[4:0], template_word[6:0]};
        legal       = fits_signed(imm, 12);
      end
      IMM_B: begin
        packed_word = {imm[12], imm[10:5], template_word[24:12], imm[4:1], imm[11],
                       template_word[6:0]};
        legal       = fits_signed(imm, 13) && !imm[0];
      end
      IMM_U: begin
        packed_word = {imm[31:12], template_word[11:0]};
        legal       = fits_signed(imm, 32) && (imm[11:0] == 12'd0);
      end
      IMM_J: begin
        packed_word = {imm[20], imm[10:1], imm[11], imm[19:12], template_word[11:0]};
        legal       = fits_signed(imm, 21) && !imm[0];
      end
      default: begin
        packed_word = template_word;
        legal       = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_packer.sv
// Streaming instruction assembler: accepts template+immediate beats, emits
// packed 32-bit words with sequential byte addresses through a single output
// register stage, and counts words whose immediate was out of range.
module instr_packer
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic              InValid,
  output logic              InReady,
  input  logic              InLast,
  input  logic [2:0]        ImmSrc,
  input  logic [31:0]       Template,
  input  logic [63:0]       Imm,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [31:0]       OutData,
  output logic [ADDR_W-1:0] OutAddr,
  output logic              OutErr,
  output logic [ERR_W-1:0]  ErrCount,
  output logic              Done
);

  pack_state_t       state_reg;
  logic              out_valid_reg;
  logic [31:0]       out_data_reg;
  logic              out_err_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ERR_W-1:0]  err_count_reg;
  logic              done_reg;

  logic [31:0] packed_word;
  logic        legal;
  logic        out_xfer;
  logic        in_acc;

  imm_pack u_imm_pack (
    .imm_src       (ImmSrc),
    .template_word (Template),
    .imm           (Imm),
    .packed_word   (packed_word),
    .legal         (legal)
  );

  // Accept only in RUN and only when the output slot is free or emptying this cycle.
  assign InReady  = (state_reg == ST_RUN) && (!out_valid_reg || OutReady);
  assign in_acc   = InValid && InReady;
  assign out_xfer = out_valid_reg && OutReady;

  assign OutValid = out_valid_reg;
  assign OutData  = out_data_reg;
  assign OutErr   = out_err_reg;
  assign OutAddr  = addr_reg;
  assign ErrCount = err_count_reg;
  assign Done     = done_reg;

  // FSM, output register, address counter and saturating error counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      out_valid_reg <= 1'b0;
      out_data_reg  <= 32'd0;
      out_err_reg   <= 1'b0;
      addr_reg      <= '0;
      err_count_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;

      if (out_xfer) begin
        addr_reg      <= addr_reg + ADDR_W'(4);
        out_valid_reg <= 1'b0;
        if (out_err_reg && (err_count_reg != {ERR_W{1'b1}}))
          err_count_reg <= err_count_reg + ERR_W'(1);
      end

      if (in_acc) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= packed_word;
        out_err_reg   <= !legal;
      end

      case (state_reg)
        ST_IDLE: begin
          if (Start) begin
            addr_reg      <= BaseAddr;
            err_count_reg <= '0;
            state_reg     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (in_acc && InLast)
            state_reg <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Only the last word can be pending here, so its transfer ends the image.
          if (out_xfer) begin
            state_reg <= ST_IDLE;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_packer.sv
// Directed bench for instr_packer: packing formats, range errors, addressing,
// backpressure, Start-in-RUN, reset mid-operation and address wrap.
module tb_instr_packer;
  import riscv_pkg::*;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [63:0] BaseAddr;
  logic        InValid;
  logic        InReady;
  logic        InLast;
  logic [2:0]  ImmSrc;
  logic [31:0] Template;
  logic [63:0] Imm;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutData;
  logic [63:0] OutAddr;
  logic        OutErr;
  logic [7:0]  ErrCount;
  logic        Done;

  int checks;
  int failures;

  instr_packer #(.ADDR_W(64), .ERR_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .Start    (Start),
    .BaseAddr (BaseAddr),
    .InValid  (InValid),
    .InReady  (InReady),
    .InLast   (InLast),
    .ImmSrc   (ImmSrc),
    .Template (Template),
    .Imm      (Imm),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .OutData  (OutData),
    .OutAddr  (OutAddr),
    .OutErr   (OutErr),
    .ErrCount (ErrCount),
    .Done     (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one clock and settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [2:0] src, input logic [31:0] tmpl,
                      input logic [63:0] im, input logic last);
    InValid  = 1'b1;
    ImmSrc   = src;
    Template = tmpl;
    Imm      = im;
    InLast   = last;
  endtask

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_inready"}, 64'(InReady), 64'd0);
    chk({pfx, "_outvalid"}, 64'(OutValid), 64'd0);
    chk({pfx, "_outerr"}, 64'(OutErr), 64'd0);
    chk({pfx, "_done"}, 64'(Done), 64'd0);
    chk({pfx, "_outdata"}, 64'(OutData), 64'd0);
    chk({pfx, "_outaddr"}, OutAddr, 64'd0);
    chk({pfx, "_errcount"}, 64'(ErrCount), 64'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    Start    = 1'b0;
    BaseAddr = 64'd0;
    InValid  = 1'b0;
    InLast   = 1'b0;
    ImmSrc   = IMM_I;
    Template = 32'd0;
    Imm      = 64'd0;
    OutReady = 1'b1;

    step();
    step();
    reset = 1'b0;
    step();
    check_reset_values("rst");

    // Three back-to-back beats from 0x1000
    Start = 1'b1; BaseAddr = 64'h1000;
    step();
    Start = 1'b0;
    chk("run_inready", 64'(InReady), 64'd1);
    chk("run_addr0", OutAddr, 64'h1000);
    beat(IMM_I, 32'h0000_0013, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    step();
    chk("i_data", 64'(OutData), 64'h0000_0000_FFF0_0013);
    chk("i_err", 64'(OutErr), 64'd0);
    chk("i_addr", OutAddr, 64'h1000);
    chk("i_valid", 64'(OutValid), 64'd1);
    beat(IMM_B, 32'h0000_0063, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    step();
    chk("b_data", 64'(OutData), 64'h0000_0000_FE00_0EE3);
    chk("b_err", 64'(OutErr), 64'd0);
    chk("b_addr", OutAddr, 64'h1004);
    beat(IMM_J, 32'h0000_006F, 64'd8, 1'b1);
    step();
    InValid = 1'b0; InLast = 1'b0;
    chk("j_data", 64'(OutData), 64'h0000_0000_0080_006F);
    chk("j_err", 64'(OutErr), 64'd0);
    chk("j_addr", OutAddr, 64'h1008);
    chk("drain_inready", 64'(InReady), 64'd0);
    chk("drain_done", 64'(Done), 64'd0);
    step();
    chk("done_pulse", 64'(Done), 64'd1);
    chk("done_valid", 64'(OutValid), 64'd0);
    chk("idle_inready", 64'(InReady), 64'd0);
    chk("done_addr", OutAddr, 64'h100C);
    step();
    chk("done_low", 64'(Done), 64'd0);

    // U-type errors, backpressure, error counting
    Start = 1'b1; BaseAddr = 64'h2000;
    step();
    Start = 1'b0;
    beat(IMM_U, 32'h0000_0037, 64'h123, 1'b0);
    OutReady = 1'b0;
    step();
    chk("u_bad_data", 64'(OutData), 64'h0000_0000_0000_0037);
    chk("u_bad_err", 64'(OutErr), 64'd1);
    beat(IMM_U, 32'h0000_0037, 64'h1234_5000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_data", 64'(OutData), 64'h0000_0000_0000_0037);
      chk("hold_addr", OutAddr, 64'h2000);
      chk("hold_inready", 64'(InReady), 64'd0);
      chk("hold_err", 64'(OutErr), 64'd1);
    end
    OutReady = 1'b1;
    #1;
    chk("release_inready", 64'(InReady), 64'd1);
    step();
    chk("u_good_data", 64'(OutData), 64'h0000_0000_1234_5037);
    chk("u_good_err", 64'(OutErr), 64'd0);
    chk("u_good_addr", OutAddr, 64'h2004);
    chk("errcount1", 64'(ErrCount), 64'd1);
    beat(IMM_I, 32'h0000_0013, 64'd2048, 1'b1);
    step();
    InValid = 1'b0; InLast = 1'b0;
    chk("i2048_err", 64'(OutErr), 64'd1);
    chk("i2048_data", 64'(OutData), 64'h0000_0000_8000_0013);
    chk("i2048_addr", OutAddr, 64'h2008);
    chk("errcount_hold", 64'(ErrCount), 64'd1);
    step();
    chk("errcount2", 64'(ErrCount), 64'd2);
    chk("done2", 64'(Done), 64'd1);
    step();

    // Start during RUN is ignored, then reset drops the pending word
    Start = 1'b1; BaseAddr = 64'h3000;
    step();
    Start = 1'b0;
    chk("restart_errcnt", 64'(ErrCount), 64'd0);
    OutReady = 1'b0;
    beat(IMM_I, 32'h0000_0013, 64'd5, 1'b0);
    step();
    InValid = 1'b0;
    chk("pend_valid", 64'(OutValid), 64'd1);
    chk("pend_data", 64'(OutData), 64'h0000_0000_0050_0013);
    Start = 1'b1; BaseAddr = 64'h9000;
    step();
    Start = 1'b0;
    chk("start_in_run", OutAddr, 64'h3000);
    reset = 1'b1;
    step();
    reset = 1'b0;
    OutReady = 1'b1;
    check_reset_values("mid");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_done", 64'(Done), 64'd0);
    end

    // Address wrap plus an illegal format code
    Start = 1'b1; BaseAddr = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    Start = 1'b0;
    beat(3'b111, 32'h1234_5678, 64'd0, 1'b1);
    step();
    InValid = 1'b0; InLast = 1'b0;
    chk("ill_data", 64'(OutData), 64'h0000_0000_1234_5678);
    chk("ill_err", 64'(OutErr), 64'd1);
    chk("wrap_addr0", OutAddr, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    chk("wrap_addr1", OutAddr, 64'd0);
    chk("wrap_done", 64'(Done), 64'd1);
    chk("wrap_errcnt", 64'(ErrCount), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
